cic_serializer: RTL and testbench

CIC_SERIALIZER -- requirements
Module: cic_serializer

---
 rtl/cic_serializer.sv | 161 ++++++++++++++++
 tb/tb_cic_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_serializer.sv
// CIC sample serializer: edge-detects the CIC output strobe, buffers samples in
// a small circular FIFO and shifts each word out MSB first with a divided
// serial clock, a full-word frame signal and an inter-word gap.
module cic_serializer #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CLK_DIV    = 2
) (
   input  logic                                clk_i,
   input  logic                                rstn_i,
   input  logic [DATA_WIDTH-1:0]               sample_data_i,
   input  logic                                cic_clk_i,
   input  logic                                enable_i,
   input  logic                                clear_ovf_i,
   output logic                                sclk_o,
   output logic                                sdata_o,
   output logic                                frame_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
   output logic                                overflow_o,
   output logic                                busy_o
);

   localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned DVW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
   localparam int unsigned CW  = $clog2(DATA_WIDTH + 1);

   localparam logic [DVW-1:0] DIV_LAST    = DVW'(2 * CLK_DIV - 1);
   localparam logic [DVW-1:0] DIV_HALF_M1 = DVW'(CLK_DIV - 1);
   localparam logic [LW-1:0]  LEVEL_FULL  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t                 state_q;
   logic                   cic_q;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]  shreg_q;
   logic [CW-1:0]          bitcnt_q;
   logic [DVW-1:0]         div_q;
   logic                   sclk_q;
   logic                   frame_q;

   logic                   strobe;
   logic                   pop;
   logic                   push;
   logic                   refused;

   // FIFO next-state: a pop in the same cycle frees a slot for a push into a full FIFO
   always_comb begin
      strobe   = cic_clk_i & ~cic_q;
      pop      = (state_q == LOAD);
      push     = strobe & ((level_q != LEVEL_FULL) | pop);
      refused  = strobe & ~push;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
      ovf_d = ovf_q;
      if (refused) begin
         ovf_d = 1'b1;
      end else if (clear_ovf_i) begin
         ovf_d = 1'b0;
      end
   end

   // Strobe edge detector, FIFO pointers, level and sticky overflow
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cic_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cic_q    <= cic_clk_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; a full-FIFO push during LOAD overwrites the slot being read,
   // which is safe because the read takes the pre-edge contents
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= sample_data_i;
      end
   end

   // Transmit FSM with registered serial outputs; the shift register is cleared
   // on leaving SHIFT so its MSB can drive sdata_o directly
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         div_q    <= '0;
         sclk_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable_i && (level_q != '0)) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               shreg_q  <= mem_q[rd_ptr_q];
               bitcnt_q <= CW'(DATA_WIDTH - 1);
               div_q    <= '0;
               sclk_q   <= 1'b0;
               frame_q  <= 1'b1;
               state_q  <= SHIFT;
            end
            SHIFT: begin
               if (div_q == DIV_LAST) begin
                  div_q  <= '0;
                  sclk_q <= 1'b0;
                  if (bitcnt_q == '0) begin
                     frame_q <= 1'b0;
                     shreg_q <= '0;
                     state_q <= GAP;
                  end else begin
                     shreg_q  <= shreg_q << 1;
                     bitcnt_q <= bitcnt_q - CW'(1);
                  end
               end else begin
                  div_q  <= div_q + DVW'(1);
                  sclk_q <= (div_q >= DIV_HALF_M1);
               end
            end
            GAP: begin
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  div_q <= div_q + DVW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sclk_o       = sclk_q;
   assign sdata_o      = shreg_q[DATA_WIDTH-1];
   assign frame_o      = frame_q;
   assign fifo_level_o = level_q;
   assign overflow_o   = ovf_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_cic_serializer.sv
// Bench for cic_serializer: directed scenarios plus randomized strobes, enables,
// clears and resets, checked every cycle against a word-timeline reference model.
module tb_cic_serializer;

   localparam int DW    = 20;
   localparam int DEPTH = 4;
   localparam int CD    = 2;
   localparam int WORDT = DW * 2 * CD;   // frame length in cycles
   localparam int GAPT  = 2 * CD;
   localparam int LAST  = WORDT + GAPT;  // offset of the final GAP cycle (LOAD is offset 0)

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [DW-1:0] data = '0;
   logic          cic = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          sclk, sdata, frame, ovf, busy;
   logic [2:0]    level;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_cur;
   bit            m_busy;
   int            m_off;
   bit            m_prev;
   bit            m_ovf;

   cic_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CD)) dut (
      .clk_i(clk), .rstn_i(rstn), .sample_data_i(data), .cic_clk_i(cic),
      .enable_i(en), .clear_ovf_i(clr), .sclk_o(sclk), .sdata_o(sdata),
      .frame_o(frame), .fifo_level_o(level), .overflow_o(ovf), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cur  = '0;
      m_busy = 0;
      m_off  = 0;
      m_prev = 0;
      m_ovf  = 0;
   endtask

   // one rising clock edge of the reference model, using the inputs held across it
   task automatic model_edge();
      bit pop, stb;
      int sz;
      if (!rstn) begin
         model_reset();
         return;
      end
      sz  = mq.size();
      pop = m_busy && (m_off == 0);
      stb = cic && !m_prev;
      m_prev = cic;
      if (pop) m_cur = mq.pop_front();
      if (stb && (sz < DEPTH || pop)) mq.push_back(data);
      if (stb && !(sz < DEPTH || pop)) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (!m_busy) begin
         if (en && sz > 0) begin
            m_busy = 1;
            m_off  = 0;
         end
      end else if (m_off == LAST) begin
         m_busy = 0;
      end else begin
         m_off++;
      end
   endtask

   task automatic compare_all();
      bit ef, es, ed;
      int k;
      ef = m_busy && m_off >= 1 && m_off <= WORDT;
      k  = ef ? m_off - 1 : 0;
      es = ef && ((k % (2 * CD)) >= CD);
      ed = ef && m_cur[DW - 1 - k / (2 * CD)];
      check("frame", frame, ef);
      check("sclk", sclk, es);
      check("sdata", sdata, ed);
      check("level", level, mq.size());
      check("overflow", ovf, m_ovf);
      check("busy", busy, m_busy);
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         compare_all();
      end
   endtask

   task automatic strobe(input logic [DW-1:0] d);
      data = d;
      cic  = 1'b1;
      step();
      cic  = 1'b0;
      step();
   endtask

   // asynchronous reset between edges; outputs must drop before any clock edge
   task automatic reset_mid(input int hold);
      #2 rstn = 1'b0;
      #1;
      check("async_frame", frame, 0);
      check("async_sclk", sclk, 0);
      check("async_sdata", sdata, 0);
      check("async_level", level, 0);
      check("async_busy", busy, 0);
      model_reset();
      @(negedge clk);
      step(hold);
      rstn = 1'b1;
   endtask

   initial begin
      model_reset();
      step(3);
      rstn = 1'b1;
      step(2);

      // single word 0xA5A5A
      en = 1'b1;
      strobe(20'hA5A5A);
      step(100);

      // fill with 1..5 while disabled: 5 dropped, then 1..4 sent in order
      en = 1'b0;
      for (int i = 1; i <= 5; i++) strobe(DW'(i));
      step(3);
      en = 1'b1;
      step(4 * 86 + 10);

      // overflow clear pulse, then clear coincident with a refused push
      clr = 1'b1; step(); clr = 1'b0; step(2);
      en = 1'b0;
      for (int i = 0; i < 4; i++) strobe(DW'($urandom));
      data = DW'($urandom); cic = 1'b1; clr = 1'b1; step();
      cic = 1'b0; clr = 1'b0; step(2);
      clr = 1'b1; step(); clr = 1'b0; step();

      // full FIFO, strobe exactly in the LOAD cycle
      en = 1'b1; step();
      data = DW'($urandom); cic = 1'b1; step();
      cic = 1'b0; step(4 * 86 + 20);

      // reset during bit 7 with an empty FIFO behind the word
      strobe(DW'($urandom));
      step(29);
      reset_mid(2);
      step(120);

      // enable dropped during bit 3 with two words queued
      en = 1'b0;
      for (int i = 0; i < 3; i++) strobe(DW'($urandom));
      en = 1'b1;
      step(14);
      en = 1'b0;
      step(200);
      en = 1'b1;
      step(2 * 86 + 10);

      // reset released while cic_clk_i is already high
      reset_mid(2);
      cic = 1'b1; data = DW'($urandom);
      step(); cic = 1'b0;
      step(100);

      // randomized traffic
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 5) == 0) cic = ~cic;
         data = DW'($urandom);
         if ($urandom_range(0, 60) == 0) en = ~en;
         clr = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 1500) == 0) reset_mid(1);
         else step();
      end
      en = 1'b1; cic = 1'b0; clr = 1'b0;
      step(6 * 86);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
